// File: rtl/i2c_slave_core_if.sv
// User-side handshake of the I2C target core: write strobes and read requests.
interface i2c_slave_core_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       busy;
  logic       error;

  modport slave (
    output rx_data,
    output rx_valid,
    output rx_first,
    output tx_req,
    output busy,
    output error,
    input  tx_data
  );

  modport master (
    input  rx_data,
    input  rx_valid,
    input  rx_first,
    input  tx_req,
    input  busy,
    input  error,
    output tx_data
  );
endinterface

// File: rtl/i2c_slave_core.sv
// 7-bit I2C target, oversampled on BUS_CLK, open-drain SDA, no clock stretching.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept general-call writes to 7'h00.
module i2c_slave_core #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic          BUS_CLK,
  input  logic          BUS_RST,
  input  logic          i2c_scl,
  inout  wire           i2c_sda,
  i2c_slave_core_if.slave u
);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam bit GcEn = 1'b1;
`else
  localparam bit GcEn = 1'b0;
`endif

  localparam logic [3:0] FCmp = 4'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_IGNORE,
    S_ADDR_ACK,
    S_RX_BYTE,
    S_RX_ACK,
    S_TX_BYTE,
    S_TX_ACK
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic [3:0] scl_cnt_q, sda_cnt_q;
  logic       scl_f_q, sda_f_q;
  logic       scl_d1_q, sda_d1_q;

  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       ack_q;
  logic       rw_q;
  logic       first_q;
  logic       rx_pend_q;
  logic       oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rx_first_q;
  logic       tx_req_q;
  logic       busy_q;
  logic       error_q;

  logic [7:0] shift_d;
  logic       scl_rise, scl_fall;
  logic       sda_rise, sda_fall;
  logic       start_c, stop_c;
  logic       addr_hit;

  // Sync then require FILTER_LEN equal samples before a filtered line moves
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_d1_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda};
      scl_d1_q   <= scl_f_q;
      sda_d1_q   <= sda_f_q;
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FCmp) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 4'd1;
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FCmp) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 4'd1;
      end
    end
  end

  assign scl_rise = scl_f_q & ~scl_d1_q;
  assign scl_fall = ~scl_f_q & scl_d1_q;
  assign sda_rise = sda_f_q & ~sda_d1_q;
  assign sda_fall = ~sda_f_q & sda_d1_q;
  assign start_c  = sda_fall & scl_f_q & scl_d1_q;
  assign stop_c   = sda_rise & scl_f_q & scl_d1_q;
  assign shift_d  = {shift_q[6:0], sda_f_q};
  assign addr_hit = (shift_d[7:1] == DEV_ADDR) ||
                    (GcEn && shift_d[7:1] == 7'h00 && !shift_d[0]);

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      ack_q      <= 1'b0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      rx_pend_q  <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (rx_pend_q) begin
        rx_pend_q  <= 1'b0;
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
        rx_first_q <= first_q;
        first_q    <= 1'b0;
      end
      if (stop_c) begin
        state_q <= S_IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start_c) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= '0;
        error_q   <= 1'b0;
        busy_q    <= 1'b0;
        oe_q      <= 1'b0;
        ack_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_ADDR: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (addr_hit) begin
                  rw_q    <= sda_f_q;
                  first_q <= ~sda_f_q;
                  ack_q   <= 1'b0;
                  state_q <= S_ADDR_ACK;
                end else begin
                  state_q <= S_IGNORE;
                end
              end
            end
          end
          // ack_q: ACK already driven, waiting for the fall that ends bit 9
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (!ack_q) begin
                oe_q   <= 1'b1;
                busy_q <= 1'b1;
                ack_q  <= 1'b1;
              end else if (rw_q) begin
                shift_q <= u.tx_data;
                oe_q    <= ~u.tx_data[7];
                state_q <= S_TX_BYTE;
              end else begin
                oe_q    <= 1'b0;
                state_q <= S_RX_BYTE;
              end
            end else if (scl_rise && ack_q && rw_q) begin
              tx_req_q <= 1'b1;
            end
          end
          S_RX_BYTE: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_pend_q <= 1'b1;
                ack_q     <= 1'b0;
                state_q   <= S_RX_ACK;
              end
            end
          end
          S_RX_ACK: begin
            if (scl_fall) begin
              if (!ack_q) begin
                oe_q  <= 1'b1;
                ack_q <= 1'b1;
              end else begin
                oe_q      <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= S_RX_BYTE;
              end
            end
          end
          // A released 1 read back as 0 means another device owns the bus
          S_TX_BYTE: begin
            if (scl_rise) begin
              if (shift_q[7] && !sda_f_q) begin
                error_q <= 1'b1;
                oe_q    <= 1'b0;
                state_q <= S_IGNORE;
              end else begin
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else if (scl_fall) begin
              if (bit_cnt_q == 3'd0) begin
                oe_q    <= 1'b0;
                ack_q   <= 1'b0;
                state_q <= S_TX_ACK;
              end else begin
                oe_q <= ~shift_q[7];
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              if (!sda_f_q) begin
                tx_req_q <= 1'b1;
                ack_q    <= 1'b1;
              end else begin
                state_q <= S_IGNORE;
              end
            end else if (scl_fall && ack_q) begin
              shift_q   <= u.tx_data;
              oe_q      <= ~u.tx_data[7];
              bit_cnt_q <= '0;
              state_q   <= S_TX_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sda    = oe_q ? 1'b0 : 1'bz;
  assign u.rx_data  = rx_data_q;
  assign u.rx_valid = rx_valid_q;
  assign u.rx_first = rx_first_q;
  assign u.tx_req   = tx_req_q;
  assign u.busy     = busy_q;
  assign u.error    = error_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: bit-banged I2C master plus vector table.
// Expectations follow the bus protocol; monitor counts strobes per transfer.
module tb_i2c_slave_core;

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  localparam int Q = 10;
  localparam int H = 20;

  logic clk = 1'b0;
  logic rst;
  logic scl;
  logic m_low;
  wire  sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_core_if u ();

  i2c_slave_core #(
    .DEV_ADDR   (7'h50),
    .FILTER_LEN (3)
  ) dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .i2c_scl (scl),
    .i2c_sda (sda),
    .u       (u)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int rx_cnt = 0;
  int first_cnt = 0;
  int tx_cnt = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] first_byte = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (u.rx_valid) begin
        rx_cnt  = rx_cnt + 1;
        last_rx = u.rx_data;
        if (u.rx_first) begin
          first_cnt  = first_cnt + 1;
          first_byte = u.rx_data;
        end
      end
      if (u.tx_req) tx_cnt = tx_cnt + 1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_bit(input logic b, input bit glitch);
    m_low = ~b;
    cyc(Q);
    scl = 1'b1;
    cyc(H / 2);
    if (glitch) begin
      scl = 1'b0;
      cyc(1);
      scl = 1'b1;
    end
    cyc(H / 2);
    scl = 1'b0;
    cyc(Q);
  endtask

  task automatic get_bit(output logic b);
    m_low = 1'b0;
    cyc(Q);
    scl = 1'b1;
    cyc(H / 2);
    b = sda;
    cyc(H / 2);
    scl = 1'b0;
    cyc(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int gbit,
                         output logic ack);
    logic nb;
    for (int i = 7; i >= 0; i--) put_bit(d[i], i == gbit);
    get_bit(nb);
    ack = ~nb;
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack, 1'b0);
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    cyc(Q);
    scl = 1'b1;
    cyc(H);
    m_low = 1'b1;
    cyc(H);
    scl = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    cyc(Q);
    scl = 1'b1;
    cyc(H);
    m_low = 1'b0;
    cyc(H);
  endtask

  task automatic clr_mon();
    rx_cnt    = 0;
    first_cnt = 0;
    tx_cnt    = 0;
  endtask

  typedef struct {
    logic [7:0] addr;
    int         nbytes;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    int         nrx;
    logic [7:0] last;
    logic [7:0] first;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic       ack;
    logic [7:0] b;

    vt[0] = '{8'hA0, 2, 8'h3C, 8'hC3, 1'b1, 2, 8'hC3, 8'h3C};
    vt[1] = '{8'hA4, 2, 8'h12, 8'h34, 1'b0, 0, 8'h00, 8'h00};
    vt[2] = '{8'h00, 1, 8'h06, 8'h00, GC, GC ? 1 : 0, 8'h06, 8'h06};
    vt[3] = '{8'hA0, 2, 8'hFF, 8'h00, 1'b1, 2, 8'h00, 8'hFF};
    vt[4] = '{8'hFE, 1, 8'h55, 8'h00, 1'b0, 0, 8'h00, 8'h00};
    vt[5] = '{8'hA0, 1, 8'h81, 8'h00, 1'b1, 1, 8'h81, 8'h81};

    rst       = 1'b1;
    scl       = 1'b1;
    m_low     = 1'b0;
    u.tx_data = 8'h00;
    cyc(5);
    rst = 1'b0;
    cyc(2);
    chk("rst_rx_data", 32'(u.rx_data), 32'h00);
    chk("rst_rx_valid", 32'(u.rx_valid), 32'h0);
    chk("rst_rx_first", 32'(u.rx_first), 32'h0);
    chk("rst_tx_req", 32'(u.tx_req), 32'h0);
    chk("rst_busy", 32'(u.busy), 32'h0);
    chk("rst_error", 32'(u.error), 32'h0);
    chk("rst_sda", 32'(sda), 32'h1);

    for (int k = 0; k < 6; k++) begin
      clr_mon();
      i2c_start();
      wr_byte(vt[k].addr, -1, ack);
      chk($sformatf("v%0d_addr_ack", k), 32'(ack), 32'(vt[k].ack));
      chk($sformatf("v%0d_busy", k), 32'(u.busy), 32'(vt[k].ack));
      if (vt[k].ack) begin
        for (int j = 0; j < vt[k].nbytes; j++) begin
          wr_byte(j == 0 ? vt[k].d0 : vt[k].d1, -1, ack);
          chk($sformatf("v%0d_d%0d_ack", k, j), 32'(ack), 32'h1);
        end
      end
      i2c_stop();
      chk($sformatf("v%0d_busy_stop", k), 32'(u.busy), 32'h0);
      chk($sformatf("v%0d_nrx", k), 32'(rx_cnt), 32'(vt[k].nrx));
      if (vt[k].nrx > 0) begin
        chk($sformatf("v%0d_last", k), 32'(last_rx), 32'(vt[k].last));
        chk($sformatf("v%0d_first", k), 32'(first_byte), 32'(vt[k].first));
        chk($sformatf("v%0d_nfirst", k), 32'(first_cnt), 32'h1);
      end else begin
        chk($sformatf("v%0d_nfirst", k), 32'(first_cnt), 32'h0);
      end
    end

    // Read two bytes, ACK then NACK
    clr_mon();
    u.tx_data = 8'h5A;
    i2c_start();
    wr_byte(8'hA1, -1, ack);
    chk("rd_addr_ack", 32'(ack), 32'h1);
    u.tx_data = 8'h96;
    rd_byte(b, 1'b0);
    chk("rd_byte0", 32'(b), 32'h5A);
    rd_byte(b, 1'b1);
    chk("rd_byte1", 32'(b), 32'h96);
    chk("rd_sda_rel", 32'(sda), 32'h1);
    chk("rd_busy_nack", 32'(u.busy), 32'h1);
    chk("rd_ntx_req", 32'(tx_cnt), 32'h2);
    i2c_stop();
    chk("rd_busy_stop", 32'(u.busy), 32'h0);

    // Write, repeated START, read with NACK
    clr_mon();
    u.tx_data = 8'h77;
    i2c_start();
    wr_byte(8'hA0, -1, ack);
    chk("rs_waddr_ack", 32'(ack), 32'h1);
    wr_byte(8'h11, -1, ack);
    chk("rs_wdata_ack", 32'(ack), 32'h1);
    i2c_start();
    wr_byte(8'hA1, -1, ack);
    chk("rs_raddr_ack", 32'(ack), 32'h1);
    rd_byte(b, 1'b1);
    chk("rs_rd", 32'(b), 32'h77);
    i2c_stop();
    chk("rs_nrx", 32'(rx_cnt), 32'h1);
    chk("rs_rx_data", 32'(last_rx), 32'h11);
    chk("rs_busy", 32'(u.busy), 32'h0);
    chk("rs_sda", 32'(sda), 32'h1);

    // One-cycle SCL glitch during the high phase of bit 3
    clr_mon();
    i2c_start();
    wr_byte(8'hA0, -1, ack);
    wr_byte(8'h5A, 3, ack);
    chk("gl_ack", 32'(ack), 32'h1);
    i2c_stop();
    chk("gl_nrx", 32'(rx_cnt), 32'h1);
    chk("gl_data", 32'(last_rx), 32'h5A);

    // Master overdrives a released 1 bit: error, sticky until START
    u.tx_data = 8'hFF;
    i2c_start();
    wr_byte(8'hA1, -1, ack);
    chk("arb_addr_ack", 32'(ack), 32'h1);
    put_bit(1'b0, 1'b0);
    chk("arb_error", 32'(u.error), 32'h1);
    i2c_stop();
    chk("arb_error_stop", 32'(u.error), 32'h1);
    i2c_start();
    chk("arb_error_clr", 32'(u.error), 32'h0);
    wr_byte(8'hA4, -1, ack);
    i2c_stop();

    // Reset while the core drives a 0 data bit
    u.tx_data = 8'h00;
    i2c_start();
    wr_byte(8'hA1, -1, ack);
    chk("rt_addr_ack", 32'(ack), 32'h1);
    chk("rt_sda_low", 32'(sda), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rt_sda_rel", 32'(sda), 32'h1);
    chk("rt_rx_data", 32'(u.rx_data), 32'h00);
    chk("rt_busy", 32'(u.busy), 32'h0);
    chk("rt_error", 32'(u.error), 32'h0);
    chk("rt_tx_req", 32'(u.tx_req), 32'h0);
    chk("rt_rx_valid", 32'(u.rx_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    i2c_stop();
    chk("rt_busy_end", 32'(u.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
